// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit.
//   estado_t       : FSM state encoding (4 bits, RESET = 0), exported as estadoAtual
//   OP_*           : 7-bit opcodes recognised in DECODE / ADDR
//   ULA_*          : estadoUla codes driven to the ALU control
//   SELB_*         : selB codes for the ALU B-input mux
//   largura_contador: width of the wait-state counter for a given MEM_WAIT
package controle_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_LOAD_IR = 4'd2,
        S_DECODE  = 4'd3,
        S_EXEC_R  = 4'd4,
        S_EXEC_I  = 4'd5,
        S_WB_ALU  = 4'd6,
        S_ADDR    = 4'd7,
        S_MEM_RD  = 4'd8,
        S_WB_LOAD = 4'd9,
        S_MEM_WR  = 4'd10,
        S_BRANCH  = 4'd11,
        S_TRAP    = 4'd12
    } estado_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    localparam logic [1:0] SELB_RS2    = 2'b00;
    localparam logic [1:0] SELB_QUATRO = 2'b01;
    localparam logic [1:0] SELB_IMM    = 2'b10;

    // A counter must hold values 0..max_val; at least one bit even for max_val = 0.
    function automatic int largura_contador(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Wait-state counter for memory accesses.
//   clk   : clock, rising edge
//   rst_n : synchronous active-high reset (clears the count)
//   clr   : synchronous clear, has priority over en
//   en    : count up by one
//   done  : count has reached MAX
module contador_espera
    import controle_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = largura_contador(MAX);

    logic [CNT_W-1:0] contagem;

    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            contagem <= '0;
        end else if (en) begin
            contagem <= contagem + CNT_W'(1);
        end
    end

    assign done = (contagem == CNT_W'(MAX));

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back for
// R-type, I-type ALU, load, store and beq. Unknown opcodes lock into TRAP.
//   clk          : clock, rising edge
//   rst_n        : synchronous reset, active HIGH despite the name
//   opcode       : opcode field from the instruction register
//   zero         : ALU zero flag (only used in BRANCH)
//   estadoUla    : ALU op (00 add, 01 sub, 10 decode by funct)
//   escritaPC    : PC write enable;   selPC: 0 ALU result, 1 branch target
//   selEnd       : memory address (0 PC, 1 ALUOut); RWmemoria: 1 write
//   escreveInstr : IR load;  escreveMDR: MDR load;  escreveReg: regfile write
//   memParaReg   : write-back source (0 ALUOut, 1 MDR)
//   selA         : ALU A (0 PC, 1 rs1); selB: ALU B (00 rs2, 01 const 4, 10 imm)
//   trap         : illegal opcode seen, sticky until reset
//   estadoAtual  : current state encoding (debug)
// Memory states (FETCH, MEM_RD, MEM_WR) last MEM_WAIT+1 cycles.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int OPCODE_W = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic [1:0]          estadoUla,
    output logic                escritaPC,
    output logic                selPC,
    output logic                selEnd,
    output logic                RWmemoria,
    output logic                escreveInstr,
    output logic                escreveMDR,
    output logic                escreveReg,
    output logic                memParaReg,
    output logic                selA,
    output logic [1:0]          selB,
    output logic                trap,
    output logic [3:0]          estadoAtual
);

    localparam logic [OPCODE_W-1:0] OPW_R     = OPCODE_W'(OP_R);
    localparam logic [OPCODE_W-1:0] OPW_I     = OPCODE_W'(OP_I);
    localparam logic [OPCODE_W-1:0] OPW_LOAD  = OPCODE_W'(OP_LOAD);
    localparam logic [OPCODE_W-1:0] OPW_STORE = OPCODE_W'(OP_STORE);
    localparam logic [OPCODE_W-1:0] OPW_BEQ   = OPCODE_W'(OP_BEQ);

    estado_t estado, proximo;
    logic    em_espera;
    logic    espera_fim;
    logic    clr_espera;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            estado <= S_RESET;
        end else begin
            estado <= proximo;
        end
    end

    // Clearing on every state change guarantees the count starts at 0 on entry
    // to a memory state, including the back-to-back MEM_WR -> FETCH case.
    assign clr_espera = (proximo != estado);

    contador_espera #(
        .MAX (MEM_WAIT)
    ) u_espera (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_espera),
        .en    (em_espera),
        .done  (espera_fim)
    );

    always_comb begin
        proximo      = estado;
        em_espera    = 1'b0;
        estadoUla    = ULA_ADD;
        escritaPC    = 1'b0;
        selPC        = 1'b0;
        selEnd       = 1'b0;
        RWmemoria    = 1'b0;
        escreveInstr = 1'b0;
        escreveMDR   = 1'b0;
        escreveReg   = 1'b0;
        memParaReg   = 1'b0;
        selA         = 1'b0;
        selB         = SELB_RS2;
        trap         = 1'b0;

        case (estado)
            S_RESET: proximo = S_FETCH;

            S_FETCH: begin
                em_espera = 1'b1;
                if (espera_fim) proximo = S_LOAD_IR;
            end

            S_LOAD_IR: begin
                escreveInstr = 1'b1;
                selB         = SELB_QUATRO;
                escritaPC    = 1'b1;
                proximo      = S_DECODE;
            end

            S_DECODE: begin
                if (opcode == OPW_R)                               proximo = S_EXEC_R;
                else if (opcode == OPW_I)                          proximo = S_EXEC_I;
                else if (opcode == OPW_LOAD || opcode == OPW_STORE) proximo = S_ADDR;
                else if (opcode == OPW_BEQ)                        proximo = S_BRANCH;
                else                                               proximo = S_TRAP;
            end

            S_EXEC_R: begin
                selA      = 1'b1;
                selB      = SELB_RS2;
                estadoUla = ULA_FUNCT;
                proximo   = S_WB_ALU;
            end

            S_EXEC_I: begin
                selA      = 1'b1;
                selB      = SELB_IMM;
                estadoUla = ULA_FUNCT;
                proximo   = S_WB_ALU;
            end

            S_WB_ALU: begin
                escreveReg = 1'b1;
                proximo    = S_FETCH;
            end

            // IR is stable here, so re-reading the opcode is safe; anything
            // other than load/store cannot arrive here unless IR was corrupted.
            S_ADDR: begin
                selA      = 1'b1;
                selB      = SELB_IMM;
                estadoUla = ULA_ADD;
                if (opcode == OPW_LOAD)       proximo = S_MEM_RD;
                else if (opcode == OPW_STORE) proximo = S_MEM_WR;
                else                          proximo = S_TRAP;
            end

            // MDR captures only on the last cycle, when read data is valid.
            S_MEM_RD: begin
                em_espera  = 1'b1;
                selEnd     = 1'b1;
                escreveMDR = espera_fim;
                if (espera_fim) proximo = S_WB_LOAD;
            end

            S_WB_LOAD: begin
                escreveReg = 1'b1;
                memParaReg = 1'b1;
                proximo    = S_FETCH;
            end

            S_MEM_WR: begin
                em_espera = 1'b1;
                selEnd    = 1'b1;
                RWmemoria = 1'b1;
                if (espera_fim) proximo = S_FETCH;
            end

            // The only Mealy-style outputs: branch taken when zero is set.
            S_BRANCH: begin
                selA      = 1'b1;
                selB      = SELB_RS2;
                estadoUla = ULA_SUB;
                escritaPC = zero;
                selPC     = zero;
                proximo   = S_FETCH;
            end

            S_TRAP: trap = 1'b1;

            default: proximo = S_RESET;
        endcase
    end

    assign estadoAtual = estado;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo. Three instances share the inputs
// with MEM_WAIT = 0, 1, 2 (instance index = MEM_WAIT); each test resets all
// of them and checks the instance whose latency the scenario calls for.
module tb_controle_multiciclo;
    import controle_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [6:0] opcode = 7'b0110011;
    logic zero = 1'b0;

    // Packed control word per instance, field order:
    // {estadoUla[1:0], escritaPC, selPC, selEnd, RWmemoria, escreveInstr,
    //  escreveMDR, escreveReg, memParaReg, selA, selB[1:0], trap}
    wire [2:0][13:0] ctl;
    wire [2:0][3:0]  st;

    int tests = 0;
    int fails = 0;

    localparam logic [13:0] C_NONE    = 14'b0;
    localparam logic [13:0] C_LOAD_IR = {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    localparam logic [13:0] C_EXEC_R  = {2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam logic [13:0] C_EXEC_I  = {2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
    localparam logic [13:0] C_WB_ALU  = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    localparam logic [13:0] C_ADDR    = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
    localparam logic [13:0] C_MEM_RD  = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    localparam logic [13:0] C_MEM_RDL = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    localparam logic [13:0] C_WB_LOAD = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    localparam logic [13:0] C_MEM_WR  = {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    localparam logic [13:0] C_BR_T    = {2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam logic [13:0] C_BR_N    = {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam logic [13:0] C_TRAP    = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        controle_multiciclo #(
            .MEM_WAIT (g),
            .OPCODE_W (7)
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .opcode       (opcode),
            .zero         (zero),
            .estadoUla    (ctl[g][13:12]),
            .escritaPC    (ctl[g][11]),
            .selPC        (ctl[g][10]),
            .selEnd       (ctl[g][9]),
            .RWmemoria    (ctl[g][8]),
            .escreveInstr (ctl[g][7]),
            .escreveMDR   (ctl[g][6]),
            .escreveReg   (ctl[g][5]),
            .memParaReg   (ctl[g][4]),
            .selA         (ctl[g][3]),
            .selB         (ctl[g][2:1]),
            .trap         (ctl[g][0]),
            .estadoAtual  (st[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int idx, input logic [3:0] es, input logic [13:0] ec, input string tag);
        tests++;
        assert (st[idx] === es) else begin
            fails++;
            $error("FAIL %s state (W=%0d): got %0d expected %0d", tag, idx, st[idx], es);
        end
        tests++;
        assert (ctl[idx] === ec) else begin
            fails++;
            $error("FAIL %s ctl (W=%0d): got %b expected %b", tag, idx, ctl[idx], ec);
        end
    endtask

    task automatic step(input int idx, input logic [3:0] es, input logic [13:0] ec, input string tag);
        tick();
        chk(idx, es, ec, tag);
    endtask

    // Hold reset 3 cycles checking every instance, then release. On return
    // the current cycle is the single RESET cycle (cycle 0).
    task automatic do_reset();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            for (int k = 0; k < 3; k++) chk(k, S_RESET, C_NONE, "reset_hold");
        end
        rst_n = 1'b0;
    endtask

    initial begin
        // R-type then I-type, MEM_WAIT=1
        opcode = 7'b0110011;
        do_reset();
        step(1, S_FETCH,   C_NONE,    "r_fetch0");
        step(1, S_FETCH,   C_NONE,    "r_fetch1");
        step(1, S_LOAD_IR, C_LOAD_IR, "r_load_ir_c3");
        step(1, S_DECODE,  C_NONE,    "r_decode");
        step(1, S_EXEC_R,  C_EXEC_R,  "r_exec");
        step(1, S_WB_ALU,  C_WB_ALU,  "r_wb_c6");
        opcode = 7'b0010011;
        step(1, S_FETCH,   C_NONE,    "i_fetch0");
        step(1, S_FETCH,   C_NONE,    "i_fetch1");
        step(1, S_LOAD_IR, C_LOAD_IR, "i_load_ir");
        step(1, S_DECODE,  C_NONE,    "i_decode");
        step(1, S_EXEC_I,  C_EXEC_I,  "i_exec");
        step(1, S_WB_ALU,  C_WB_ALU,  "i_wb");
        step(1, S_FETCH,   C_NONE,    "i_next_fetch");

        // Load, MEM_WAIT=2: 10 cycles, MDR loads only on the 3rd MEM_RD cycle
        opcode = 7'b0000011;
        do_reset();
        step(2, S_FETCH,   C_NONE,    "ld_fetch0");
        step(2, S_FETCH,   C_NONE,    "ld_fetch1");
        step(2, S_FETCH,   C_NONE,    "ld_fetch2");
        step(2, S_LOAD_IR, C_LOAD_IR, "ld_load_ir");
        step(2, S_DECODE,  C_NONE,    "ld_decode");
        step(2, S_ADDR,    C_ADDR,    "ld_addr");
        step(2, S_MEM_RD,  C_MEM_RD,  "ld_mem0");
        step(2, S_MEM_RD,  C_MEM_RD,  "ld_mem1");
        step(2, S_MEM_RD,  C_MEM_RDL, "ld_mem2_mdr");
        step(2, S_WB_LOAD, C_WB_LOAD, "ld_wb_c10");
        step(2, S_FETCH,   C_NONE,    "ld_next_fetch");

        // Store then beq taken / not taken, MEM_WAIT=0
        opcode = 7'b0100011;
        do_reset();
        step(0, S_FETCH,   C_NONE,    "st_fetch");
        step(0, S_LOAD_IR, C_LOAD_IR, "st_load_ir");
        step(0, S_DECODE,  C_NONE,    "st_decode");
        step(0, S_ADDR,    C_ADDR,    "st_addr");
        step(0, S_MEM_WR,  C_MEM_WR,  "st_mem_wr");
        step(0, S_FETCH,   C_NONE,    "st_next_fetch");
        opcode = 7'b1100011;
        zero   = 1'b1;
        step(0, S_LOAD_IR, C_LOAD_IR, "beq1_load_ir");
        step(0, S_DECODE,  C_NONE,    "beq1_decode");
        step(0, S_BRANCH,  C_BR_T,    "beq1_taken");
        zero   = 1'b0;
        step(0, S_FETCH,   C_NONE,    "beq1_fetch");
        step(0, S_LOAD_IR, C_LOAD_IR, "beq0_load_ir");
        step(0, S_DECODE,  C_NONE,    "beq0_decode");
        step(0, S_BRANCH,  C_BR_N,    "beq0_not_taken");
        step(0, S_FETCH,   C_NONE,    "beq0_fetch");

        // Illegal opcode, MEM_WAIT=1: sticky TRAP, cleared by reset
        opcode = 7'b1111111;
        do_reset();
        step(1, S_FETCH,   C_NONE,    "tr_fetch0");
        step(1, S_FETCH,   C_NONE,    "tr_fetch1");
        step(1, S_LOAD_IR, C_LOAD_IR, "tr_load_ir");
        step(1, S_DECODE,  C_NONE,    "tr_decode");
        for (int c = 0; c < 20; c++) step(1, S_TRAP, C_TRAP, "tr_hold");
        rst_n = 1'b1;
        step(1, S_RESET,   C_NONE,    "tr_cleared");

        // Reset asserted during MEM_WR, MEM_WAIT=2: write aborts next cycle
        opcode = 7'b0100011;
        do_reset();
        step(2, S_FETCH,   C_NONE,    "ab_fetch0");
        step(2, S_FETCH,   C_NONE,    "ab_fetch1");
        step(2, S_FETCH,   C_NONE,    "ab_fetch2");
        step(2, S_LOAD_IR, C_LOAD_IR, "ab_load_ir");
        step(2, S_DECODE,  C_NONE,    "ab_decode");
        step(2, S_ADDR,    C_ADDR,    "ab_addr");
        step(2, S_MEM_WR,  C_MEM_WR,  "ab_mem_wr");
        rst_n = 1'b1;
        step(2, S_RESET,   C_NONE,    "ab_aborted");
        step(2, S_RESET,   C_NONE,    "ab_held");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
